// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared opcodes, FSM state encodings and constants for mdu_iter.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // Opcodes presented on op
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // FSM state encodings
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t S_IDLE = 2'd0;
  localparam mdu_state_t S_MUL  = 2'd1;
  localparam mdu_state_t S_DIV  = 2'd2;
  localparam mdu_state_t S_FIX  = 2'd3;

  // Iterations per multiply/divide, one result bit per cycle
  localparam int ITER = 32;

  // Magnitude of an operand: absolute value when treated as signed.
  // The most negative value maps to 0x80000000, which is its correct
  // unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Brief    : One combinational restoring-division step: shift in the next
//            dividend bit, trial-subtract the divisor, keep or restore.
// Revision : 1.0  initial release
// ============================================================================
module mdu_div_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [32:0] w_shift;
  logic [33:0] w_diff;

  // Trial subtraction; a clear borrow bit means the divisor fits
  always_comb begin
    w_shift = {rem_i[31:0], bit_i};
    w_diff  = {1'b0, w_shift} - {2'b00, divisor_i};
    q_o     = ~w_diff[33];
    rem_o   = q_o ? w_diff[32:0] : w_shift;
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative MIPS32 multiply/divide unit with HI/LO registers.
//            Shift-add multiply and restoring divide, 32 cycles each, followed
//            by a sign-fixup/commit cycle.
// Revision : 1.0  initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;       // multiply: {partial product, multiplier}
  logic [31:0] mcand_q, mcand_d;
  logic [32:0] rem_q, rem_d;       // divide: partial remainder
  logic [31:0] quo_q, quo_d;       // divide: dividend shifting out, quotient in
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_p_q, neg_p_d;   // negate product / quotient
  logic        neg_r_q, neg_r_d;   // negate remainder
  logic        dz_q, dz_d;         // divide by zero: commit nothing
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [32:0] w_sum;
  logic [32:0] w_rem_nxt;
  logic        w_qbit;
  logic [63:0] w_prod;
  logic        w_signed;

  mdu_div_step u_div_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[31]),
    .divisor_i (dvsr_q),
    .rem_o     (w_rem_nxt),
    .q_o       (w_qbit)
  );

  // Next-state logic: accept, iterate, fix up signs and commit; flush last
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    w_sum    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};
    w_prod   = neg_p_q ? (~acc_q + 64'd1) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              mcand_d  = mag(in1, w_signed);
              acc_d    = {32'd0, mag(in2, w_signed)};
              neg_p_d  = w_signed & (in1[31] ^ in2[31]);
              neg_r_d  = w_signed & in1[31];
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              cnt_d    = 6'd0;
              state_d  = S_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              quo_d    = mag(in1, w_signed);
              dvsr_d   = mag(in2, w_signed);
              rem_d    = 33'd0;
              neg_p_d  = w_signed & (in1[31] ^ in2[31]);
              neg_r_d  = w_signed & in1[31];
              is_div_d = 1'b1;
              dz_d     = (in2 == 32'd0);
              cnt_d    = 6'd0;
              state_d  = (in2 == 32'd0) ? S_FIX : S_DIV;
            end
            MDU_MTHI: hi_d = in1;
            MDU_MTLO: lo_d = in1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {w_sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        rem_d = w_rem_nxt;
        quo_d = {quo_q[30:0], w_qbit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      end
      default: begin
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = neg_r_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
            lo_d = neg_p_q ? (~quo_q + 32'd1) : quo_q;
          end else begin
            hi_d = w_prod[63:32];
            lo_d = w_prod[31:0];
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Squash: nothing committed, nothing started, no completion pulse
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 32'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed self-checking bench for mdu_iter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  mdu_iter dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge is the accept edge E0.
  // Returns at the falling edge after E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts edges since E0; bounded so a missing done cannot hang the run
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    vt[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33};
    vt[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vt[3] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vt[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vt[5] = '{MDU_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 33};
    vt[6] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vt[7] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vt[8] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vt[9] = '{MDU_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 33};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven arithmetic
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done(0, lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Back-to-back: new start in the cycle done is high
    issue(MDU_MULTU, 32'd3, 32'd5);
    wait_done(0, lat);
    chk("b2b_first_lo", lo, 15);
    issue(MDU_MULTU, 32'd6, 32'd7);
    wait_done(0, lat);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_lo", lo, 42);
    @(negedge clk);

    // Divide by zero with preloaded HI/LO
    issue(MDU_MTHI, 32'h1111, 32'd0);
    issue(MDU_MTLO, 32'h2222, 32'd0);
    issue(MDU_DIVU, 32'd5, 32'd0);
    wait_done(0, lat);
    chk("dz_latency", lat, 1);
    chk("dz_hi", hi, 32'h1111);
    chk("dz_lo", lo, 32'h2222);
    @(negedge clk);
    chk("dz_done_once", done, 0);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = MDU_MTHI; in1 = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", busy, 0);
    op = MDU_MTLO; in1 = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_kept", hi, 32'hDEADBEEF);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    @(negedge clk);
    chk("mtx_done_after", done, 0);

    // Reserved opcodes do nothing
    issue(3'd6, 32'hAAAAAAAA, 32'd1);
    issue(3'd7, 32'hBBBBBBBB, 32'd1);
    chk("op67_hi", hi, 32'hDEADBEEF);
    chk("op67_lo", lo, 32'h12345678);
    chk("op67_busy", busy, 0);

    // Flush at E10 of a multiply
    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_done", done, 0);
    end
    chk("flush_hi", hi, 32'hDEADBEEF);
    chk("flush_lo", lo, 32'h12345678);
    issue(MDU_MULTU, 32'd3, 32'd5);
    wait_done(0, lat);
    chk("post_flush_latency", lat, 33);
    chk("post_flush_lo", lo, 15);
    chk("post_flush_hi", hi, 0);
    @(negedge clk);

    // Flush coinciding with FIX suppresses the commit
    issue(MDU_MULTU, 32'd9, 32'd9);
    repeat (32) @(negedge clk);
    chk("fixflush_busy_in_fix", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fixflush_done", done, 0);
    chk("fixflush_busy", busy, 0);
    chk("fixflush_lo", lo, 15);
    @(negedge clk);
    chk("fixflush_done_late", done, 0);

    // Start while a divide is running is ignored
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = MDU_MULTU; in1 = 32'd3; in2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    chk("busy_start_latency", lat, 33);
    chk("busy_start_lo", lo, 14);
    chk("busy_start_hi", hi, 2);
    @(negedge clk);
    chk("busy_start_no_second", busy, 0);

    // Reset at E20 of a divide
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    chk("midrst_stays_idle", busy, 0);
    chk("midrst_no_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
